// File: rtl/mega_mul_unit.sv
// mega_mul_unit
// Sequential shift-add multiplier covering the MUL/MULS/MULSU and
// FMUL/FMULS/FMULSU family. Operands are reduced to magnitudes at capture,
// multiplied one bit per clock, then sign/fraction corrected in a final step.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst_n          asynchronous active-low reset
//   start          request, sampled only while idle
//   flush          synchronous cancel of the operation in progress
//   mode[2:0]      000 MUL, 001 MULS, 010 MULSU, 011 FMUL, 100 FMULS,
//                  101 FMULSU, 110/111 treated as MUL
//   in_1[W-1:0]    multiplicand (signed operand for the SU variants)
//   in_2[W-1:0]    multiplier (unsigned operand for the SU variants)
//   busy           operation in progress
//   done           one-cycle pulse: out and flags newly valid
//   out[2W-1:0]    product
//   ALU_FLAG_C_OUT carry flag (MSB of the unshifted product)
//   ALU_FLAG_Z_OUT zero flag (out == 0)
module mega_mul_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               flush,
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   in_1,
  input  logic [WIDTH-1:0]   in_2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out,
  output logic               ALU_FLAG_C_OUT,
  output logic               ALU_FLAG_Z_OUT
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_nxt;

  // Magnitude of an operand. The most negative value maps onto 2^(W-1),
  // which still fits when the result is read back as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic signed [WIDTH-1:0] neg_v;
    neg_v = -v;
    return (is_signed && (v < 0)) ? neg_v : v;
  endfunction

  // Sign and fraction correction: {carry, corrected product}.
  // Carry is taken from the signed product before the fractional shift.
  function automatic logic [PW:0] fix_product(input logic [PW-1:0] mag_prod,
                                              input logic neg,
                                              input logic frac);
    logic signed [PW-1:0] p;
    logic        [PW-1:0] o;
    p = neg ? -$signed(mag_prod) : $signed(mag_prod);
    o = frac ? {p[PW-2:0], 1'b0} : p;
    return {p[PW-1], o};
  endfunction

  logic sgn_1, sgn_2, frac_sel;
  logic accept, finish, step;
  logic [PW:0] fixed;

  logic [PW-1:0]    mcand_p0;
  logic [WIDTH-1:0] mplier_p0;
  logic             neg_p0;
  logic             frac_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic [PW-1:0]    acc_p1;

  always_comb begin
    sgn_1    = 1'b0;
    sgn_2    = 1'b0;
    frac_sel = 1'b0;
    case (mode)
      3'b001: begin sgn_1 = 1'b1; sgn_2 = 1'b1; end
      3'b010: begin sgn_1 = 1'b1; end
      3'b011: begin frac_sel = 1'b1; end
      3'b100: begin sgn_1 = 1'b1; sgn_2 = 1'b1; frac_sel = 1'b1; end
      3'b101: begin sgn_1 = 1'b1; frac_sel = 1'b1; end
      default: ;
    endcase
  end

  // flush in IDLE also blocks a simultaneous start
  assign accept = (state == IDLE) && start && !flush;
  assign step   = (state == RUN) && !flush;
  assign finish = (state == FIX) && !flush;
  assign busy   = (state != IDLE);
  assign fixed  = fix_product(acc_p1, neg_p0, frac_p0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (flush) state_nxt = IDLE;
               else if (cnt_p0 == LAST_STEP) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture stage: operand magnitudes, result sign and fraction flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_p0  <= '0;
      mplier_p0 <= '0;
      neg_p0    <= 1'b0;
      frac_p0   <= 1'b0;
      cnt_p0    <= '0;
      acc_p1    <= '0;
    end else if (accept) begin
      mcand_p0  <= PW'(magnitude($signed(in_1), sgn_1));
      mplier_p0 <= magnitude($signed(in_2), sgn_2);
      neg_p0    <= (in_1[WIDTH-1] & sgn_1) ^ (in_2[WIDTH-1] & sgn_2);
      frac_p0   <= frac_sel;
      cnt_p0    <= '0;
      acc_p1    <= '0;
    end else if (step) begin
      // Shift-add stage: one multiplier bit per edge
      if (mplier_p0[0]) acc_p1 <= acc_p1 + mcand_p0;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
      cnt_p0    <= cnt_p0 + CNT_W'(1);
    end
  end

  // Correction stage: results only change on a completed operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done           <= 1'b0;
      out            <= '0;
      ALU_FLAG_C_OUT <= 1'b0;
      ALU_FLAG_Z_OUT <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        out            <= fixed[PW-1:0];
        ALU_FLAG_C_OUT <= fixed[PW];
        ALU_FLAG_Z_OUT <= (fixed[PW-1:0] == '0);
      end
    end
  end

endmodule

// File: tb/tb_mega_mul_unit.sv
module tb_mega_mul_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic [7:0]  in_1 = 8'h00;
  logic [7:0]  in_2 = 8'h00;
  logic        busy, done;
  logic [15:0] out;
  logic        c_flag, z_flag;

  int n_tests = 0;
  int n_fail  = 0;

  mega_mul_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .mode(mode),
    .in_1(in_1), .in_2(in_2), .busy(busy), .done(done), .out(out),
    .ALU_FLAG_C_OUT(c_flag), .ALU_FLAG_Z_OUT(z_flag)
  );

  always #5 clk = ~clk;

  // Reference: true integer product of the operands as the mode interprets
  // them, truncated to 16 bits. Returns {C, Z, out}.
  function automatic logic [17:0] model(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
    longint sa, sb, p;
    logic [15:0] pr, o;
    logic fr;
    sa = (m == 3'd1 || m == 3'd2 || m == 3'd4 || m == 3'd5) ? longint'($signed(a)) : longint'(a);
    sb = (m == 3'd1 || m == 3'd4) ? longint'($signed(b)) : longint'(b);
    fr = (m == 3'd3 || m == 3'd4 || m == 3'd5);
    p  = sa * sb;
    pr = p[15:0];
    o  = fr ? {pr[14:0], 1'b0} : pr;
    return {pr[15], (o == 16'h0000), o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from a negedge. Optionally injects a second start
  // (inj) or a flush (fl) at the given cycle count after capture. Returns at
  // the negedge where done is seen high, or after a bounded wait.
  task automatic op(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                    input int inj, input int fl,
                    output int lat, output int bcnt, output int bafter, output logic seen);
    mode = m; in_1 = a; in_2 = b; start = 1'b1; flush = 1'b0;
    @(negedge clk);
    lat = 0; bcnt = 0; bafter = -1; seen = 1'b0;
    while (lat < 20) begin
      start = 1'b0; flush = 1'b0;
      if (done) begin seen = 1'b1; break; end
      if (busy) bcnt++;
      if (fl >= 0 && lat == fl + 1) bafter = int'(busy);
      if (lat == inj) begin
        start = 1'b1; in_1 = ~a; in_2 = b ^ 8'h5A; mode = m ^ 3'b011;
      end
      if (lat == fl) flush = 1'b1;
      @(negedge clk);
      lat++;
    end
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic run_chk(input string tag, input logic [2:0] m, input logic [7:0] a, input logic [7:0] b, input int inj);
    int lat, bcnt, bafter;
    logic seen;
    logic [17:0] e;
    e = model(m, a, b);
    op(m, a, b, inj, -1, lat, bcnt, bafter, seen);
    chk({tag, "_done"}, seen, 1);
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_busycyc"}, bcnt, 9);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_out"}, out, e[15:0]);
    chk({tag, "_c"}, c_flag, e[17]);
    chk({tag, "_z"}, z_flag, e[16]);
  endtask

  initial begin
    int lat, bcnt, bafter;
    logic seen;
    logic [15:0] prev;
    logic [2:0] rm;
    logic [7:0] ra, rb;

    #1 rst_n = 1'b0;
    #7;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", out, 0);
    chk("rst_c", c_flag, 0);
    chk("rst_z", z_flag, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // flush together with start while idle must not start anything
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_busy", busy, 0);
    @(negedge clk);
    chk("idle_flush_done", done, 0);

    run_chk("mul_ff", 3'd0, 8'hFF, 8'hFF, -1);
    chk("mul_ff_const", {c_flag, z_flag, out}, {1'b1, 1'b0, 16'hFE01});
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("out_hold", out, 16'hFE01);

    run_chk("muls", 3'd1, 8'h80, 8'h80, -1);
    chk("muls_const", {c_flag, out}, {1'b0, 16'h4000});
    run_chk("mulsu", 3'd2, 8'hFF, 8'h02, -1);
    chk("mulsu_const", {c_flag, out}, {1'b1, 16'hFFFE});
    run_chk("fmul", 3'd3, 8'h80, 8'h80, -1);
    chk("fmul_const", {c_flag, out}, {1'b0, 16'h8000});
    run_chk("fmuls", 3'd4, 8'hC0, 8'h40, -1);
    chk("fmuls_const", {c_flag, out}, {1'b1, 16'hE000});
    run_chk("mul_zero", 3'd0, 8'h00, 8'h37, -1);
    chk("mul_zero_const", {c_flag, z_flag, out}, {1'b0, 1'b1, 16'h0000});

    // start during RUN ignored; then a back-to-back start in the done cycle
    run_chk("ign_start", 3'd0, 8'h12, 8'h34, 2);
    chk("ign_start_const", out, 16'h03A8);
    run_chk("b2b", 3'd5, 8'h9C, 8'hE7, -1);

    // flush mid-run: no done, previous result retained
    @(negedge clk);
    prev = out;
    op(3'd0, 8'hAB, 8'hCD, -1, 4, lat, bcnt, bafter, seen);
    chk("flush_no_done", seen, 0);
    chk("flush_idle", bafter, 0);
    chk("flush_out_kept", out, prev);
    chk("flush_busy_end", busy, 0);
    run_chk("after_flush", 3'd1, 8'h7F, 8'h81, -1);

    // reset in the middle of a run
    mode = 3'd0; in_1 = 8'h55; in_2 = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out", out, 0);
    chk("midrst_done", done, 0);
    chk("midrst_c", c_flag, 0);
    @(negedge clk);
    chk("midrst_hold_done", done, 0);
    rst_n = 1'b1;
    run_chk("after_rst", 3'd0, 8'h55, 8'hAA, -1);

    for (int i = 0; i < 40; i++) begin
      rm = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_chk($sformatf("rnd%0d", i), rm, ra, rb, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
